mips_alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the combinational MIPS R-type ALU. Decodes the 6-bit function field, completes logic/arithmetic/shift ops in one cycle and runs iterative mult/div over WIDTH cycles into internal HI/LO registers. A start/busy/done handshake connects it to the multi-cycle datapath controller. Operands come from the register-file read ports read_data_1 / read_data_2.

---
 rtl/mips_alu_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_alu_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_seq.sv
// Multi-cycle MIPS R-type ALU: one-cycle logic/arith/shift ops, WIDTH-cycle iterative mult/div into HI/LO.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH busy cycles then done for mult/div.
// Backpressure: start is taken only when busy=0; a start while busy is dropped, never queued.
module mips_alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         functionField,
  input  logic [WIDTH-1:0]   read_data_1,
  input  logic [WIDTH-1:0]   read_data_2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   aluResult,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               div_zero,
  output logic               invalid
);
  localparam int W = WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  localparam logic [5:0] F_SLL   = 6'b000000, F_SRL  = 6'b000010, F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000, F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010, F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100, F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110, F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010, F_SLTU = 6'b101011;

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  // Iteration register: [2W:W] running partial product / remainder, [W-1:0] multiplier / quotient.
  logic [2*W:0]       p_q, p_d;
  logic [W-1:0]       b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               neg_p_q, neg_p_d;
  logic               neg_r_q, neg_r_d;
  logic [W-1:0]       res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic               ovf_q, ovf_d, dz_q, dz_d, inv_q, inv_d;

  logic [W-1:0]        a, b, sum, diff, abs_a, abs_b;
  logic signed [W-1:0] b_s;
  logic                op_signed, add_ovf, sub_ovf;
  logic [W:0]          mul_sum, div_trial;
  logic [2*W:0]        mul_step, div_sh, div_step, step;
  logic [2*W-1:0]      prod;
  logic [W-1:0]        quo, rem;

  assign a   = read_data_1;
  assign b   = read_data_2;
  assign b_s = read_data_2;

  // Operand-side arithmetic and the per-cycle mult/div step with final sign correction.
  always_comb begin
    sum       = a + b;
    diff      = a - b;
    add_ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    sub_ovf   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    // Signed mult/div run on magnitudes; the sign is reapplied at completion.
    op_signed = (functionField == F_MULT) || (functionField == F_DIV);
    abs_a     = (op_signed && a[W-1]) ? -a : a;
    abs_b     = (op_signed && b[W-1]) ? -b : b;

    mul_sum   = p_q[2*W:W] + (p_q[0] ? {1'b0, b_q} : '0);
    mul_step  = {mul_sum, p_q[W-1:0]} >> 1;
    // Restoring division; bit W of the trial difference is the borrow.
    div_sh    = {p_q[2*W-1:0], 1'b0};
    div_trial = div_sh[2*W:W] - {1'b0, b_q};
    div_step  = div_trial[W] ? div_sh : {div_trial, div_sh[W-1:1], 1'b1};
    step      = is_div_q ? div_step : mul_step;

    prod = neg_p_q ? -step[2*W-1:0] : step[2*W-1:0];
    quo  = neg_p_q ? -step[W-1:0]   : step[W-1:0];
    rem  = neg_r_q ? -step[2*W-1:W] : step[2*W-1:W];
  end

  // FSM next state, op decode at acceptance, and iteration/completion updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    res_d    = res_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    inv_d    = inv_q;
    case (state_q)
      S_EXEC: begin
        p_d = step;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (is_div_q) begin
            lo_d  = quo;
            hi_d  = rem;
            res_d = quo;
          end else begin
            hi_d  = prod[2*W-1:W];
            lo_d  = prod[W-1:0];
            res_d = prod[W-1:0];
          end
        end else begin
          cnt_d = cnt_q + SHAMT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_DONE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          inv_d   = 1'b0;
          case (functionField)
            F_ADD:  begin res_d = sum;  ovf_d = add_ovf; end
            F_ADDU: res_d = sum;
            F_SUB:  begin res_d = diff; ovf_d = sub_ovf; end
            F_SUBU: res_d = diff;
            F_AND:  res_d = a & b;
            F_OR:   res_d = a | b;
            F_XOR:  res_d = a ^ b;
            F_NOR:  res_d = ~(a | b);
            F_SLT:  res_d = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU: res_d = {{(W-1){1'b0}}, (a < b)};
            F_SLL:  res_d = b << shamt;
            F_SRL:  res_d = b >> shamt;
            F_SRA:  res_d = b_s >>> shamt;
            F_MFHI: res_d = hi_q;
            F_MFLO: res_d = lo_q;
            F_MULT, F_MULTU: begin
              state_d  = S_EXEC;
              is_div_d = 1'b0;
              p_d      = {{(W+1){1'b0}}, abs_a};
              b_d      = abs_b;
              neg_p_d  = op_signed && (a[W-1] ^ b[W-1]);
              neg_r_d  = 1'b0;
            end
            F_DIV, F_DIVU: begin
              if (b == '0) begin
                // No iteration: quotient saturates to all ones, remainder is the dividend.
                dz_d  = 1'b1;
                lo_d  = '1;
                hi_d  = a;
                res_d = '1;
              end else begin
                state_d  = S_EXEC;
                is_div_d = 1'b1;
                p_d      = {{(W+1){1'b0}}, abs_a};
                b_d      = abs_b;
                neg_p_d  = op_signed && (a[W-1] ^ b[W-1]);
                neg_r_d  = op_signed && a[W-1];
              end
            end
            default: begin
              res_d = '0;
              inv_d = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  // State registers with synchronous reset; reset also aborts an in-flight mult/div.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      inv_q    <= inv_d;
    end
  end

  assign aluResult = res_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == S_EXEC);
  assign done      = (state_q == S_DONE);
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;
  assign invalid   = inv_q;
endmodule

// File: tb/tb_mips_alu_seq.sv
// Directed bench for mips_alu_seq at WIDTH=32 and WIDTH=16.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each feature has its own task with inline comparisons against hand-computed values.
module tb_mips_alu_seq;
  localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101, F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111, F_SLT  = 6'b101010, F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU = 6'b011011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [5:0]  functionField;
  logic [31:0] read_data_1, read_data_2, aluResult, hi, lo;
  logic [4:0]  shamt;
  logic        busy, done, overflow, div_zero, invalid;

  logic        start16;
  logic [5:0]  functionField16;
  logic [15:0] read_data_1_16, read_data_2_16, aluResult16, hi16, lo16;
  logic [3:0]  shamt16;
  logic        busy16, done16, overflow16, div_zero16, invalid16;

  int tests = 0;
  int fails = 0;

  mips_alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .functionField(functionField),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .shamt(shamt),
    .aluResult(aluResult), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .overflow(overflow), .div_zero(div_zero), .invalid(invalid)
  );

  mips_alu_seq #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .functionField(functionField16),
    .read_data_1(read_data_1_16), .read_data_2(read_data_2_16), .shamt(shamt16),
    .aluResult(aluResult16), .hi(hi16), .lo(lo16), .busy(busy16), .done(done16),
    .overflow(overflow16), .div_zero(div_zero16), .invalid(invalid16)
  );

  // Present one op for one cycle, then scramble the inputs to prove they were captured.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] bb,
                       input logic [4:0] sh);
    @(negedge clk);
    start = 1'b1; functionField = f; read_data_1 = a; read_data_2 = bb; shamt = sh;
    @(negedge clk);
    start = 1'b0; functionField = 6'b111110; read_data_1 = 32'hDEAD_BEEF;
    read_data_2 = 32'h1234_5678; shamt = 5'd17;
  endtask

  task automatic issue16(input logic [5:0] f, input logic [15:0] a, input logic [15:0] bb);
    @(negedge clk);
    start16 = 1'b1; functionField16 = f; read_data_1_16 = a; read_data_2_16 = bb; shamt16 = 4'd0;
    @(negedge clk);
    start16 = 1'b0; functionField16 = 6'b111110; read_data_1_16 = 16'hBEEF;
    read_data_2_16 = 16'h5678;
  endtask

  // Count busy cycles until done, bounded.
  task automatic wait_done(output int nb, output bit got);
    nb = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start16 = 1'b0;
    functionField = 6'd0; read_data_1 = '0; read_data_2 = '0; shamt = '0;
    functionField16 = 6'd0; read_data_1_16 = '0; read_data_2_16 = '0; shamt16 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if ({aluResult, hi, lo} !== 96'd0) begin fails++;
      $display("FAIL reset_regs: got %h/%h/%h want 0", aluResult, hi, lo); end
    tests++; if ({busy, done, overflow, div_zero, invalid} !== 5'b0) begin fails++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, overflow, div_zero, invalid}); end
    tests++; if ({aluResult16, hi16, lo16, busy16, done16} !== 50'd0) begin fails++;
      $display("FAIL reset_w16: got %h/%h/%h %b%b want 0", aluResult16, hi16, lo16, busy16, done16); end
  endtask

  task automatic test_single_cycle();
    logic [5:0] f; logic [31:0] a, bb, er; logic [4:0] sh; logic eo;
    for (int i = 0; i < 14; i++) begin
      sh = 5'd0; eo = 1'b0;
      case (i)
        0:  begin f = F_ADD;  a = 32'h0043_5020; bb = 32'h0067_5021; er = 32'h00AA_A041; end
        1:  begin f = F_SUB;  a = 32'h0043_5020; bb = 32'h0067_5021; er = 32'hFFDB_FFFF; end
        2:  begin f = F_SLT;  a = 32'h0043_5020; bb = 32'h0067_5021; er = 32'd1; end
        3:  begin f = F_SLTU; a = 32'h0043_5020; bb = 32'h0067_5021; er = 32'd1; end
        4:  begin f = F_ADD;  a = 32'h7FFF_FFFF; bb = 32'h1; er = 32'h8000_0000; eo = 1'b1; end
        5:  begin f = F_ADDU; a = 32'h7FFF_FFFF; bb = 32'h1; er = 32'h8000_0000; end
        6:  begin f = F_SUB;  a = 32'h8000_0000; bb = 32'h1; er = 32'h7FFF_FFFF; eo = 1'b1; end
        7:  begin f = F_SRA;  a = 32'h0; bb = 32'h8000_0000; sh = 5'd4; er = 32'hF800_0000; end
        8:  begin f = F_SRL;  a = 32'h0; bb = 32'h8000_0000; sh = 5'd4; er = 32'h0800_0000; end
        9:  begin f = F_SLL;  a = 32'h0; bb = 32'h1; sh = 5'd31; er = 32'h8000_0000; end
        10: begin f = F_AND;  a = 32'hF0F0_1234; bb = 32'hFF00_00FF; er = 32'hF000_0034; end
        11: begin f = F_OR;   a = 32'hF0F0_1234; bb = 32'hFF00_00FF; er = 32'hFFF0_12FF; end
        12: begin f = F_XOR;  a = 32'hF0F0_1234; bb = 32'hFF00_00FF; er = 32'h0FF0_12CB; end
        default: begin f = F_NOR; a = 32'hF0F0_1234; bb = 32'hFF00_00FF; er = 32'h000F_ED00; end
      endcase
      issue(f, a, bb, sh);
      tests++; if (done !== 1'b1) begin fails++;
        $display("FAIL single_done[%0d]: got %b want 1", i, done); end
      tests++; if (aluResult !== er) begin fails++;
        $display("FAIL single_result[%0d]: got %h want %h", i, aluResult, er); end
      tests++; if (overflow !== eo) begin fails++;
        $display("FAIL single_ovf[%0d]: got %b want %b", i, overflow, eo); end
    end
    @(negedge clk);
    tests++; if (done !== 1'b0 || aluResult !== 32'h000F_ED00) begin fails++;
      $display("FAIL done_drop: got done=%b res=%h want 0/000fed00", done, aluResult); end
  endtask

  task automatic test_mult();
    int nb; bit got;
    issue(F_MULT, 32'd7, 32'hFFFF_FFFD, 5'd0);
    nb = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) nb++;
      // A start while busy must be ignored, not queued.
      if (busy && nb == 5) begin
        start = 1'b1; functionField = F_ADD; read_data_1 = 32'd1; read_data_2 = 32'd1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    tests++; if (!got || nb != 32) begin fails++;
      $display("FAIL mult_cycles: got done=%b busy_cycles=%0d want 1/32", got, nb); end
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL mult_busy_at_done: got %b want 0", busy); end
    tests++; if ({hi, lo, aluResult} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB}) begin fails++;
      $display("FAIL mult_result: got %h %h %h want ffffffff ffffffeb ffffffeb", hi, lo, aluResult); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL mult_no_queue: got done=%b busy=%b want 0/0", done, busy); end
    issue(F_MFHI, 32'd0, 32'd0, 5'd0);
    tests++; if (aluResult !== 32'hFFFF_FFFF) begin fails++;
      $display("FAIL mfhi: got %h want ffffffff", aluResult); end
    issue(F_MFLO, 32'd0, 32'd0, 5'd0);
    tests++; if (aluResult !== 32'hFFFF_FFEB) begin fails++;
      $display("FAIL mflo: got %h want ffffffeb", aluResult); end
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_done(nb, got);
    tests++; if (!got || {hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin fails++;
      $display("FAIL multu: got done=%b %h_%h want fffffffe_00000001", got, hi, lo); end
  endtask

  task automatic test_div();
    int nb; bit got; logic [5:0] f; logic [31:0] a, bb, eq, er;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin f = F_DIVU; a = 32'd100;       bb = 32'd7;  eq = 32'd14;        er = 32'd2; end
        1: begin f = F_DIV;  a = 32'hFFFF_FF9C; bb = 32'd7;  eq = 32'hFFFF_FFF2; er = 32'hFFFF_FFFE; end
        2: begin f = F_DIV;  a = 32'd100;       bb = 32'hFFFF_FFF9; eq = 32'hFFFF_FFF2; er = 32'd2; end
        default: begin f = F_DIVU; a = 32'hFFFF_FFFF; bb = 32'd16; eq = 32'h0FFF_FFFF; er = 32'hF; end
      endcase
      issue(f, a, bb, 5'd0);
      wait_done(nb, got);
      tests++; if (!got || nb != 32) begin fails++;
        $display("FAIL div_cycles[%0d]: got done=%b busy_cycles=%0d want 1/32", i, got, nb); end
      tests++; if ({lo, hi, aluResult} !== {eq, er, eq}) begin fails++;
        $display("FAIL div_result[%0d]: got lo=%h hi=%h res=%h want %h %h %h", i, lo, hi, aluResult, eq, er, eq); end
    end
    issue(F_DIV, 32'd5, 32'd0, 5'd0);
    tests++; if (done !== 1'b1 || div_zero !== 1'b1) begin fails++;
      $display("FAIL divzero_flag: got done=%b dz=%b want 1/1", done, div_zero); end
    tests++; if ({lo, hi, aluResult} !== {32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF}) begin fails++;
      $display("FAIL divzero_result: got %h %h %h want ffffffff 5 ffffffff", lo, hi, aluResult); end
  endtask

  task automatic test_invalid();
    issue(6'b111111, 32'd3, 32'd4, 5'd0);
    tests++; if (invalid !== 1'b1 || div_zero !== 1'b0 || aluResult !== 32'd0) begin fails++;
      $display("FAIL invalid: got inv=%b dz=%b res=%h want 1/0/0", invalid, div_zero, aluResult); end
    tests++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin fails++;
      $display("FAIL invalid_hilo: got %h %h want 5 ffffffff", hi, lo); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; functionField = F_ADD; read_data_1 = 32'd10; read_data_2 = 32'd20;
    @(negedge clk);
    tests++; if (done !== 1'b1 || aluResult !== 32'd30 || invalid !== 1'b0) begin fails++;
      $display("FAIL b2b_first: got done=%b res=%h inv=%b want 1/1e/0", done, aluResult, invalid); end
    functionField = F_SUB; read_data_1 = 32'd50; read_data_2 = 32'd8;
    @(negedge clk);
    start = 1'b0;
    tests++; if (done !== 1'b1 || aluResult !== 32'd42) begin fails++;
      $display("FAIL b2b_second: got done=%b res=%h want 1/2a", done, aluResult); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || aluResult !== 32'd42) begin fails++;
      $display("FAIL b2b_hold: got done=%b res=%h want 0/2a", done, aluResult); end
  endtask

  task automatic test_reset_abort();
    issue(F_MULT, 32'd123, 32'd456, 5'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || {hi, lo, aluResult} !== 96'd0) begin fails++;
      $display("FAIL abort: got busy=%b done=%b %h %h %h want 0/0/0", busy, done, hi, lo, aluResult); end
    issue(F_ADD, 32'd2, 32'd3, 5'd0);
    tests++; if (done !== 1'b1 || aluResult !== 32'd5) begin fails++;
      $display("FAIL post_abort_add: got done=%b res=%h want 1/5", done, aluResult); end
  endtask

  task automatic test_width16();
    logic [5:0] f; logic [15:0] er; logic eo; int nb; bit got;
    for (int i = 0; i < 4; i++) begin
      eo = 1'b0;
      case (i)
        0: begin f = F_ADD;  er = 16'hA041; eo = 1'b1; end
        1: begin f = F_SUB;  er = 16'hFFFF; end
        2: begin f = F_SLT;  er = 16'd1; end
        default: begin f = F_SLTU; er = 16'd1; end
      endcase
      issue16(f, 16'h5020, 16'h5021);
      tests++; if (done16 !== 1'b1 || aluResult16 !== er || overflow16 !== eo) begin fails++;
        $display("FAIL w16_single[%0d]: got done=%b res=%h ovf=%b want 1/%h/%b", i, done16, aluResult16, overflow16, er, eo); end
    end
    issue16(F_MULT, 16'd7, 16'hFFFD);
    nb = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done16) begin got = 1'b1; break; end
      if (busy16) nb++;
      @(negedge clk);
    end
    tests++; if (!got || nb != 16) begin fails++;
      $display("FAIL w16_mult_cycles: got done=%b busy_cycles=%0d want 1/16", got, nb); end
    tests++; if ({hi16, lo16, aluResult16} !== {16'hFFFF, 16'hFFEB, 16'hFFEB}) begin fails++;
      $display("FAIL w16_mult: got %h %h %h want ffff ffeb ffeb", hi16, lo16, aluResult16); end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mult();
    test_div();
    test_invalid();
    test_back_to_back();
    test_reset_abort();
    test_width16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
